// File: rtl/logcap_pkg.sv
// Shared definitions for the log-capture UART path: arbiter states, grant IDs and the
// hub-visible UART data port address.
package logcap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StHub,
    StStream
  } arb_state_e;

  localparam logic GrantHub    = 1'b0;
  localparam logic GrantStream = 1'b1;

  // Hub register address that produces hub_write strobes toward this block.
  localparam logic [7:0] UartDataAddr = 8'h04;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the hub/streamer/UART FIFO and the UART TX arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface uart_tx_arbiter_if #(
  parameter int unsigned HUB_FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(HUB_FIFO_DEPTH) + 1;

  logic [7:0]        hub_data;
  logic              hub_write;
  logic [LevelW-1:0] hub_level;
  logic              hub_overflow;
  logic              hub_overflow_clear;
  logic [7:0]        strm_data;
  logic              strm_valid;
  logic              strm_last;
  logic              strm_ready;
  logic [7:0]        data_tx;
  logic              utx_buffer_write;
  logic              utx_buffer_full;
  logic              busy;

  modport slave (
    input  hub_data, hub_write, hub_overflow_clear,
    input  strm_data, strm_valid, strm_last, utx_buffer_full,
    output hub_level, hub_overflow, strm_ready, data_tx, utx_buffer_write, busy
  );

  modport master (
    output hub_data, hub_write, hub_overflow_clear,
    output strm_data, strm_valid, strm_last, utx_buffer_full,
    input  hub_level, hub_overflow, strm_ready, data_tx, utx_buffer_write, busy
  );

endinterface

// File: rtl/hub_tx_fifo.sv
// Small synchronous byte FIFO for hub writes. Pointers carry an extra wrap bit so
// full and empty are distinguishable; a push while full is taken only with a same-cycle pop.
module hub_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [7:0]                push_data,
  input  logic                      pop,
  output logic [7:0]                pop_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      full,
  output logic                      empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        push_ok, pop_ok;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = wptr_q - rptr_q;
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign pop_data = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO between buffered hub bytes and atomic stream frames,
// alternating turns when both are pending, through a one-entry output register.
module uart_tx_arbiter
  import logcap_pkg::*;
#(
  parameter int unsigned HUB_FIFO_DEPTH = 4,
  parameter int unsigned HUB_BURST_MAX  = 16
) (
  input  logic               clk,
  input  logic               reset,
  uart_tx_arbiter_if.slave   bus
);
  localparam int unsigned LevelW = $clog2(HUB_FIFO_DEPTH) + 1;

  arb_state_e        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [7:0]        burst_q, burst_d;
  logic              out_valid_q;
  logic [7:0]        out_data_q;
  logic              overflow_q;

  logic              fifo_pop, fifo_full, fifo_empty;
  logic [7:0]        fifo_data;
  logic [LevelW-1:0] fifo_level;
  logic              utx_write, load_ok, out_load, strm_ready;
  logic [7:0]        out_load_data;

  hub_tx_fifo #(
    .DEPTH (HUB_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.hub_write),
    .push_data (bus.hub_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign utx_write = out_valid_q & ~bus.utx_buffer_full;
  assign load_ok   = ~out_valid_q | utx_write;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    burst_d       = burst_q;
    fifo_pop      = 1'b0;
    strm_ready    = 1'b0;
    out_load      = 1'b0;
    out_load_data = out_data_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && (!bus.strm_valid || last_grant_q == GrantStream)) begin
          state_d      = StHub;
          last_grant_d = GrantHub;
          burst_d      = '0;
        end else if (bus.strm_valid) begin
          state_d      = StStream;
          last_grant_d = GrantStream;
        end
      end
      StHub: begin
        if (fifo_empty) begin
          state_d = StIdle;
        end else if (load_ok) begin
          fifo_pop      = 1'b1;
          out_load      = 1'b1;
          out_load_data = fifo_data;
          if (burst_q != 8'hFF) burst_d = burst_q + 8'd1;
          // Leave on the pop that hits the burst limit or drains the last byte.
          if ((32'(burst_q) + 32'd1 >= HUB_BURST_MAX) ||
              (fifo_level == LevelW'(1) && !bus.hub_write)) begin
            state_d = StIdle;
          end
        end
      end
      StStream: begin
        strm_ready = load_ok;
        if (load_ok && bus.strm_valid) begin
          out_load      = 1'b1;
          out_load_data = bus.strm_data;
          if (bus.strm_last) state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= GrantStream;
      burst_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      burst_q      <= burst_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (out_load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= out_load_data;
    end else if (utx_write) begin
      out_valid_q <= 1'b0;
    end
  end

  // A dropped byte wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (bus.hub_write && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end else if (bus.hub_overflow_clear) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.hub_level        = fifo_level;
  assign bus.hub_overflow     = overflow_q;
  assign bus.strm_ready       = strm_ready;
  assign bus.data_tx          = out_data_q;
  assign bus.utx_buffer_write = utx_write;
  assign bus.busy             = (state_q != StIdle) | out_valid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: records every UART FIFO write and compares
// against hand-computed byte orders and reset/backpressure values.
module tb_uart_tx_arbiter;
  localparam int unsigned Depth    = 4;
  localparam int unsigned BurstMax = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.HUB_FIFO_DEPTH(Depth)) bus ();

  uart_tx_arbiter #(
    .HUB_FIFO_DEPTH (Depth),
    .HUB_BURST_MAX  (BurstMax)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] wq[$];
  int wc[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.utx_buffer_write === 1'b1) begin
      wq.push_back(bus.data_tx);
      wc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] base, input int n, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int waited;
      bit ok;
      bus.strm_valid = 1'b1;
      bus.strm_data  = base + 8'(i);
      bus.strm_last  = with_last && (i == n - 1);
      waited = 0;
      ok = 1'b0;
      while (!ok && waited < 100) begin
        @(negedge clk);
        if (bus.strm_ready === 1'b1) ok = 1'b1;
        else waited++;
      end
      total++;
      if (!ok) begin
        bad++;
        $display("FAIL stream_handshake: byte %02h strm_ready stayed 0 for 100 cycles, want 1",
                 bus.strm_data);
      end
      tick();
    end
    bus.strm_valid = 1'b0;
    bus.strm_last  = 1'b0;
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++; if (bus.hub_level !== 3'd0) begin bad++;
      $display("FAIL reset_level: got %0d want 0", bus.hub_level); end
    total++; if (bus.hub_overflow !== 1'b0) begin bad++;
      $display("FAIL reset_overflow: got %b want 0", bus.hub_overflow); end
    total++; if (bus.utx_buffer_write !== 1'b0) begin bad++;
      $display("FAIL reset_write: got %b want 0", bus.utx_buffer_write); end
    total++; if (bus.data_tx !== 8'h00) begin bad++;
      $display("FAIL reset_data: got %02h want 00", bus.data_tx); end
    total++; if (bus.strm_ready !== 1'b0) begin bad++;
      $display("FAIL reset_ready: got %b want 0", bus.strm_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy: got %b want 0", bus.busy); end
    tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_hub_only();
    clear_log();
    exp_q = '{8'h41, 8'h42, 8'h43};
    bus.hub_write = 1'b1;
    bus.hub_data = 8'h41; tick();
    bus.hub_data = 8'h42; tick();
    bus.hub_data = 8'h43; tick();
    bus.hub_write = 1'b0;
    repeat (10) tick();
    total++; if (wq.size() != 3) begin bad++;
      $display("FAIL hub_only_count: got %0d writes want 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL hub_only_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
    if (wc.size() == 3) begin
      total++; if (wc[2] - wc[0] != 2) begin bad++;
        $display("FAIL hub_only_consecutive: span %0d cycles want 2", wc[2] - wc[0]); end
    end
    @(negedge clk);
    total++; if (bus.hub_level !== 3'd0) begin bad++;
      $display("FAIL hub_only_level: got %0d want 0", bus.hub_level); end
    tick();
  endtask

  task automatic test_frame_atomic();
    clear_log();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h10 + 8'(i));
    exp_q.push_back(8'hAA);
    fork
      send_frame(8'h10, 8, 1'b1);
      begin
        repeat (4) tick();
        bus.hub_data = 8'hAA;
        bus.hub_write = 1'b1;
        tick();
        bus.hub_write = 1'b0;
      end
    join
    repeat (10) tick();
    total++; if (wq.size() != 9) begin bad++;
      $display("FAIL atomic_count: got %0d writes want 9", wq.size()); end
    for (int i = 0; i < 9; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL atomic_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
    if (wc.size() >= 8) begin
      total++; if (wc[7] - wc[0] != 7) begin bad++;
        $display("FAIL atomic_contiguous: span %0d cycles want 7", wc[7] - wc[0]); end
    end
  endtask

  task automatic test_overflow();
    clear_log();
    exp_q = '{8'h20, 8'h21, 8'h31, 8'h32, 8'h33, 8'h34};
    send_frame(8'h20, 1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.hub_data = 8'h31 + 8'(i);
      bus.hub_write = 1'b1;
      tick();
    end
    bus.hub_write = 1'b0;
    @(negedge clk);
    total++; if (bus.hub_level !== 3'd4) begin bad++;
      $display("FAIL ovf_level: got %0d want 4", bus.hub_level); end
    total++; if (bus.hub_overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_flag: got %b want 1", bus.hub_overflow); end
    tick();
    bus.hub_data = 8'h36;
    bus.hub_write = 1'b1;
    bus.hub_overflow_clear = 1'b1;
    tick();
    bus.hub_write = 1'b0;
    bus.hub_overflow_clear = 1'b0;
    @(negedge clk);
    total++; if (bus.hub_overflow !== 1'b1) begin bad++;
      $display("FAIL ovf_set_beats_clear: got %b want 1", bus.hub_overflow); end
    total++; if (bus.hub_level !== 3'd4) begin bad++;
      $display("FAIL ovf_level_held: got %0d want 4", bus.hub_level); end
    tick();
    bus.hub_overflow_clear = 1'b1;
    tick();
    bus.hub_overflow_clear = 1'b0;
    @(negedge clk);
    total++; if (bus.hub_overflow !== 1'b0) begin bad++;
      $display("FAIL ovf_clear: got %b want 0", bus.hub_overflow); end
    tick();
    send_frame(8'h21, 1, 1'b1);
    repeat (12) tick();
    total++; if (wq.size() != 6) begin bad++;
      $display("FAIL ovf_count: got %0d writes want 6", wq.size()); end
    for (int i = 0; i < 6; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL ovf_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h50 + 8'(i));
    fork
      send_frame(8'h50, 8, 1'b1);
      begin
        repeat (4) tick();
        bus.utx_buffer_full = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          total++; if (bus.utx_buffer_write !== 1'b0) begin bad++;
            $display("FAIL bp_write c%0d: got %b want 0", c, bus.utx_buffer_write); end
          total++; if (bus.strm_ready !== 1'b0) begin bad++;
            $display("FAIL bp_ready c%0d: got %b want 0", c, bus.strm_ready); end
          total++; if (bus.data_tx !== 8'h52) begin bad++;
            $display("FAIL bp_data c%0d: got %02h want 52", c, bus.data_tx); end
        end
        tick();
        bus.utx_buffer_full = 1'b0;
      end
    join
    repeat (10) tick();
    total++; if (wq.size() != 8) begin bad++;
      $display("FAIL bp_count: got %0d writes want 8", wq.size()); end
    for (int i = 0; i < 8; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL bp_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
  endtask

  task automatic test_fairness();
    clear_log();
    for (int i = 0; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 4; i++)  exp_q.push_back(8'h60 + 8'(i));
    for (int i = 16; i < 20; i++) exp_q.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 4; i++)  exp_q.push_back(8'h70 + 8'(i));
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          bus.hub_data = 8'h80 + 8'(i);
          bus.hub_write = 1'b1;
          tick();
        end
        bus.hub_write = 1'b0;
      end
      begin
        tick();
        send_frame(8'h60, 4, 1'b1);
        send_frame(8'h70, 4, 1'b1);
      end
    join
    repeat (15) tick();
    total++; if (wq.size() != 28) begin bad++;
      $display("FAIL fair_count: got %0d writes want 28", wq.size()); end
    for (int i = 0; i < 28; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL fair_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
    if (wc.size() >= 16) begin
      total++; if (wc[15] - wc[0] != 15) begin bad++;
        $display("FAIL fair_burst_rate: span %0d cycles want 15", wc[15] - wc[0]); end
    end
    total++; if (bus.hub_overflow !== 1'b0) begin bad++;
      $display("FAIL fair_overflow: got %b want 0", bus.hub_overflow); end
  endtask

  task automatic test_reset_mid();
    clear_log();
    exp_q = '{8'h90, 8'h91, 8'h92};
    bus.hub_data = 8'hEE;
    bus.hub_write = 1'b1;
    bus.strm_valid = 1'b1;
    bus.strm_last = 1'b0;
    bus.strm_data = 8'h90;
    tick();
    bus.hub_write = 1'b0;
    tick();
    bus.strm_data = 8'h91; tick();
    bus.strm_data = 8'h92; tick();
    bus.strm_data = 8'h93;
    reset = 1'b1;
    bus.strm_valid = 1'b0;
    tick();
    @(negedge clk);
    total++; if (bus.utx_buffer_write !== 1'b0) begin bad++;
      $display("FAIL rst_mid_write: got %b want 0", bus.utx_buffer_write); end
    total++; if (bus.data_tx !== 8'h00) begin bad++;
      $display("FAIL rst_mid_data: got %02h want 00", bus.data_tx); end
    total++; if (bus.strm_ready !== 1'b0) begin bad++;
      $display("FAIL rst_mid_ready: got %b want 0", bus.strm_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++;
      $display("FAIL rst_mid_busy: got %b want 0", bus.busy); end
    total++; if (bus.hub_level !== 3'd0) begin bad++;
      $display("FAIL rst_mid_level: got %0d want 0", bus.hub_level); end
    tick();
    reset = 1'b0;
    repeat (10) tick();
    total++; if (wq.size() != 3) begin bad++;
      $display("FAIL rst_mid_count: got %0d writes want 3", wq.size()); end
    for (int i = 0; i < 3; i++) begin
      logic [7:0] got;
      got = (i < wq.size()) ? wq[i] : 8'hxx;
      total++; if (got !== exp_q[i]) begin bad++;
        $display("FAIL rst_mid_byte%0d: got %02h want %02h", i, got, exp_q[i]); end
    end
  endtask

  initial begin
    bus.hub_data = 8'h00;
    bus.hub_write = 1'b0;
    bus.hub_overflow_clear = 1'b0;
    bus.strm_data = 8'h00;
    bus.strm_valid = 1'b0;
    bus.strm_last = 1'b0;
    bus.utx_buffer_full = 1'b0;
    test_reset();
    test_hub_only();
    test_frame_atomic();
    test_overflow();
    test_backpressure();
    test_fairness();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single UART transmit buffer between two requesters: the command/control hub (processor byte writes to the UART data port, fire-and-forget strobes) and the capture-dump streamer (bulk sample bytes with valid/ready and frame delimiting). The block sits between the hub's `data_tx`/`utx_buffer_write` outputs and the UART TX FIFO. It buffers hub bytes in a small FIFO, keeps stream frames atomic, and alternates fairly between requesters.

## Interface
- `HUB_FIFO_DEPTH`, 4, depth of the hub byte FIFO; a power of two, 2..16.
- `HUB_BURST_MAX`, 16, maximum hub bytes sent per hub turn; range 1..255.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `hub_data`  in  8  byte from hub processor write.
- `hub_write`  in  1  single-cycle strobe; byte is pushed this cycle.
- `hub_level`  out  $clog2(HUB_FIFO_DEPTH)+1  hub FIFO occupancy.
- `hub_overflow`  out  1  sticky; a hub byte was dropped.
- `hub_overflow_clear`  in  1  clears `hub_overflow`.
- `strm_data`  in  8  stream byte.
- `strm_valid`  in  1  stream byte valid.
- `strm_last`  in  1  byte is the final byte of the frame.
- `strm_ready`  out  1  stream byte accepted when `strm_valid & strm_ready`.
- `data_tx`  out  8  byte to the UART TX FIFO.
- `utx_buffer_write`  out  1  UART TX FIFO write strobe.
- `utx_buffer_full`  in  1  UART TX FIFO full.
- `busy`  out  1  high whenever state is not IDLE or the output register is occupied.

## Operation
- Hub FIFO: a push occurs every cycle `hub_write`=1. If the FIFO is full and no pop happens that cycle, the byte is dropped and `hub_overflow` is set. Push while full with a simultaneous pop is accepted and the level is unchanged.
- `hub_overflow`: set has priority over `hub_overflow_clear` in the same cycle.
- Output stage: a one-entry register (`out_valid`, `out_data`). `data_tx` = `out_data`. `utx_buffer_write` = `out_valid & ~utx_buffer_full`, which is combinational from `utx_buffer_full`. The register loads when `~out_valid | utx_buffer_write`.
- FSM states:
  - IDLE -> HUB if only hub is pending (`hub_level`>0).
  - IDLE -> STREAM if only `strm_valid`.
  - If both are pending, the requester not granted last goes first (`last_grant` bit; reset value = STREAM, so the hub wins the first tie).
  - HUB: pop one byte into the output register per load opportunity. Return to IDLE after HUB_BURST_MAX bytes or when the FIFO empties.
  - STREAM: `strm_ready` = load opportunity. The frame is locked until the byte with `strm_last` is accepted, then go to IDLE. Hub bytes are only buffered during STREAM.
- Burst counter: 8 bits, cleared on HUB entry, no wrap; the exit compare uses `HUB_BURST_MAX`.
- `strm_ready` = 0 outside STREAM.

## Timing
- Reset values:
  - state = IDLE, `last_grant` = STREAM.
  - FIFO empty, `hub_level`=0, `hub_overflow`=0.
  - `out_valid`=0, `data_tx`=0, `utx_buffer_write`=0.
  - `strm_ready`=0, `busy`=0.
- Grant latency: IDLE to first load takes 1 cycle (state registered, load in the next cycle).
- Byte latency: load at edge t; `utx_buffer_write` is asserted in cycle t+1 if not full.
- Throughput: 1 byte/cycle sustained while `utx_buffer_full`=0, including across the HUB/STREAM boundary, except for the 1-cycle IDLE bubble.
- Full: `out_data` is held stable, the write is suppressed, and loads stall. No byte is lost or duplicated.
- Stream idle mid-frame (`strm_valid`=0): the block stays in STREAM and the hub waits. The hub FIFO may overflow; this is by design.
- Reset mid-operation:
  - FIFO contents and the output register are discarded and the frame is aborted.
  - The streamer must restart its frame after reset.
  - No `utx_buffer_write` in the cycle following reset.

## Structure
- Shared package `logcap_pkg`: FSM state encoding (IDLE, HUB, STREAM), grant ID constants, and the UART port address constant shared with the hub.
- Sub-module `hub_tx_fifo`: synchronous FIFO with push/pop, level, and full/empty flags. Pointers are $clog2(DEPTH) bits with an extra wrap bit.
- Top level: FSM, burst counter, output register, overflow flag.

## Test plan
- Hub only: 3 `hub_write` strobes with 0x41, 0x42, 0x43 and full=0 -> `utx_buffer_write` on 3 consecutive cycles with 0x41, 0x42, 0x43; `hub_level` returns to 0.
- Frame atomicity: stream frame 0x10..0x17 with `last` on 0x17; hub writes 0xAA mid-frame -> 0x10..0x17 are contiguous on `data_tx`, then 0xAA.
- Overflow: DEPTH=4, stream frame stalled mid-frame, 5 hub writes -> `hub_level`=4 and `hub_overflow`=1. Clear together with a 6th write -> `hub_overflow` stays 1.
- Backpressure: hold `utx_buffer_full`=1 for 10 cycles mid-stream -> `data_tx` is stable, no write is issued, `strm_ready`=0. On release, bytes resume with no loss or duplication.
- Fairness: hub holds 20 bytes arriving continuously while stream frames are back-to-back -> hub sends 16 bytes (HUB_BURST_MAX), then one full frame, then the remaining hub bytes.
- Reset mid-frame: reset during byte 3 of a frame -> all outputs at reset values next cycle, FIFO empty, state IDLE.
